// File: rtl/pool5_rm_reader.sv
`default_nettype none
// ============================================================================
// Module   : pool5_rm_reader
// Purpose  : Read controller for the pool5 result RAM. A start pulse streams
//            a contiguous run of 64-bit words from the RAM read port out as a
//            valid/ready stream. A credit-limited show-ahead FIFO absorbs the
//            fixed RAM read latency so backpressure never drops or repeats data.
// Ports    : clk, rst_n (async, active-low)
//            start, base_addr, word_cnt   - transfer request (sampled in IDLE)
//            ram_addrb / ram_doutb        - RAM read port (enable tied high)
//            m_valid, m_data, m_last, m_ready - output stream
//            busy, done                   - status
// Options  : POOL5_RD_REPEAT_EN adds input num_pass (0 treated as 1); the run
//            is streamed num_pass times back-to-back, with one m_last and
//            one done at the very end.
// Revision : 1.0 - initial release
// ============================================================================
module pool5_rm_reader #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 64,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_cnt,
`ifdef POOL5_RD_REPEAT_EN
    input  logic [3:0]        num_pass,
`endif
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_doutb,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IFL_W = $clog2(RD_LAT + 1);
`ifdef POOL5_RD_REPEAT_EN
    localparam int OUT_W = ADDR_W + 5;
`else
    localparam int OUT_W = ADDR_W + 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     issue_rem_q, issue_rem_d, nxt_rem;
    logic [OUT_W-1:0]    out_rem_q, out_rem_d, total_cnt;
    logic [RD_LAT-1:0]   tag_q, tag_d;
    logic [IFL_W-1:0]    inflight_q, inflight_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic                issue, credit, wr, pop;
`ifdef POOL5_RD_REPEAT_EN
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     word_q, word_d;
    logic [3:0]          pass_rem_q, pass_rem_d, passes;
`endif

    // Show-ahead FIFO outputs
    assign m_valid = (count_q != '0);
    assign m_data  = mem_q[rd_ptr_q];
    assign m_last  = m_valid && (out_rem_q == OUT_W'(1));
    assign busy    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done    = done_q;

    assign pop = m_valid && m_ready;
    // The oldest tag marks the cycle in which ram_doutb carries issued data.
    assign wr  = tag_q[RD_LAT-1];
    // Reads in flight plus FIFO occupancy must never exceed the FIFO depth,
    // so every tagged word has a guaranteed slot when it returns.
    assign credit = (issue_rem_q != '0) &&
                    ((32'(inflight_q) + 32'(count_q)) < 32'(FIFO_DEPTH));

`ifdef POOL5_RD_REPEAT_EN
    assign passes    = (num_pass == 4'd0) ? 4'd1 : num_pass;
    assign total_cnt = OUT_W'(word_cnt) * OUT_W'(passes);
`else
    assign total_cnt = word_cnt;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_rem_d = issue_rem_q;
        out_rem_d   = out_rem_q;
        nxt_rem     = issue_rem_q;
        done_d      = 1'b0;
        issue       = 1'b0;
        ram_addrb   = addr_q;
`ifdef POOL5_RD_REPEAT_EN
        base_d      = base_q;
        word_d      = word_q;
        pass_rem_d  = pass_rem_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    out_rem_d = total_cnt;
`ifdef POOL5_RD_REPEAT_EN
                    base_d     = base_addr;
                    word_d     = word_cnt;
                    pass_rem_d = passes - 4'd1;
`endif
                    if (word_cnt == '0) begin
                        state_d = S_FIN;
                    end else begin
                        // First read goes out in the start cycle itself so
                        // the first beat appears RD_LAT+1 cycles later.
                        issue     = 1'b1;
                        ram_addrb = base_addr;
                        addr_d    = base_addr + ADDR_W'(1);
                        nxt_rem   = word_cnt - (ADDR_W+1)'(1);
                        state_d   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (credit) begin
                    issue   = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                    nxt_rem = issue_rem_q - (ADDR_W+1)'(1);
                end
            end
            S_DRAIN: begin
                if (pop && (out_rem_q == OUT_W'(1))) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                // Non-empty runs already pulsed done on the last pop; only an
                // empty run raises it here.
                done_d  = ~done_q;
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            issue_rem_d = nxt_rem;
            if (nxt_rem == '0) begin
`ifdef POOL5_RD_REPEAT_EN
                if (pass_rem_d != 4'd0) begin
                    pass_rem_d  = pass_rem_d - 4'd1;
                    addr_d      = base_d;
                    issue_rem_d = word_d;
                end else begin
                    state_d = S_DRAIN;
                end
`else
                state_d = S_DRAIN;
`endif
            end
        end

        if (pop && (out_rem_q != '0)) begin
            out_rem_d = out_rem_q - OUT_W'(1);
            if (out_rem_q == OUT_W'(1)) begin
                done_d = 1'b1;
            end
        end
    end

    always_comb begin
        tag_d      = RD_LAT'({tag_q, issue});
        inflight_d = inflight_q + IFL_W'(issue) - IFL_W'(wr);
        count_d    = count_q + CNT_W'(wr) - CNT_W'(pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(wr);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            issue_rem_q <= '0;
            out_rem_q   <= '0;
            tag_q       <= '0;
            inflight_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef POOL5_RD_REPEAT_EN
            base_q      <= '0;
            word_q      <= '0;
            pass_rem_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_rem_q <= issue_rem_d;
            out_rem_q   <= out_rem_d;
            tag_q       <= tag_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            done_q      <= done_d;
            if (wr) begin
                mem_q[wr_ptr_q] <= ram_doutb;
            end
`ifdef POOL5_RD_REPEAT_EN
            base_q      <= base_d;
            word_q      <= word_d;
            pass_rem_q  <= pass_rem_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pool5_rm_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pool5_rm_reader
// Purpose  : Self-checking bench for pool5_rm_reader. A 2-cycle-latency RAM
//            holds random words; each transfer's expected beats are the RAM
//            contents at base..base+cnt-1 (mod 4096), held in a queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pool5_rm_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic [12:0] word_cnt = '0;
    logic [11:0] ram_addrb;
    logic [63:0] ram_doutb;
    logic        m_valid;
    logic [63:0] m_data;
    logic        m_last;
    logic        m_ready = 1'b0;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pool5_rm_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .word_cnt  (word_cnt),
`ifdef POOL5_RD_REPEAT_EN
        .num_pass  (4'd1),
`endif
        .ram_addrb (ram_addrb),
        .ram_doutb (ram_doutb),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .busy      (busy),
        .done      (done)
    );

    // RAM model: address registered, then data registered (2-cycle latency)
    logic [63:0] ram [4096];
    logic [11:0] ram_a1;
    always @(posedge clk) begin
        ram_a1    <= ram_addrb;
        ram_doutb <= ram[ram_a1];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'($urandom % 2);
        if (k >= 8 && k < 18) return 1'b0;
        return 1'(k % 2);
    endfunction

    // mode 0: ready high, 1: random ready, 2: toggle + 10-cycle stall
    task automatic run_xfer(input string nm, input logic [11:0] base, input int cnt,
                            input int mode, input int restart_k, input int rst_after);
        logic [63:0] expq [$];
        int k, beats, dones, first_k, done_k, last_k, busy_cnt;
        logic [11:0] addr_snap;
        logic [11:0] a;
        beats = 0; dones = 0; first_k = -1; done_k = -1; last_k = -1; busy_cnt = 0;
        addr_snap = '0;
        for (int i = 0; i < cnt; i++) begin
            a = base + 12'(i);
            expq.push_back(ram[a]);
        end
        @(negedge clk);
        start = 1'b1; base_addr = base; word_cnt = 13'(cnt); m_ready = rdy(mode, 0);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        if (cnt != 0) chk({nm, "_busy1"}, 64'(busy), 64'd1);
        while (k <= 400) begin
            m_ready = rdy(mode, k);
            start = (restart_k > 0 && k == restart_k);
            if (start) begin
                base_addr = ~base; word_cnt = 13'd5;
            end
            if (mode == 2 && k == 12) addr_snap = ram_addrb;
            if (mode == 2 && k == 17) chk({nm, "_credit_hold"}, 64'(ram_addrb), 64'(addr_snap));
            if (busy) busy_cnt++;
            if (m_valid) begin
                if (first_k < 0) first_k = k;
                if (expq.size() == 0) begin
                    chk({nm, "_extra_beat"}, 64'(m_valid), 64'd0);
                end else begin
                    chk({nm, "_data"}, m_data, expq[0]);
                    chk({nm, "_last"}, 64'(m_last), 64'(expq.size() == 1));
                    if (m_ready) begin
                        void'(expq.pop_front());
                        beats++;
                        last_k = k;
                    end
                end
            end
            if (done) begin
                dones++;
                done_k = k;
            end
            if (rst_after > 0 && beats == rst_after) break;
            if (dones > 0 && k >= done_k + 4) break;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (rst_after > 0) return;
        chk({nm, "_beats"}, 64'(beats), 64'(cnt));
        chk({nm, "_dones"}, 64'(dones), 64'd1);
        if (cnt > 0) begin
            chk({nm, "_first_lat"}, 64'(first_k), 64'd3);
            chk({nm, "_done_lat"}, 64'(done_k), 64'(last_k + 1));
            if (mode == 0) chk({nm, "_no_bubble"}, 64'(last_k - first_k), 64'(cnt - 1));
        end else begin
            chk({nm, "_done_lat"}, 64'(done_k), 64'd2);
            chk({nm, "_no_valid"}, 64'(first_k), 64'hFFFF_FFFF_FFFF_FFFF);
            chk({nm, "_busy_short"}, 64'(busy_cnt <= 1), 64'd1);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_addr"},  64'(ram_addrb), 64'd0);
        chk({nm, "_valid"}, 64'(m_valid),   64'd0);
        chk({nm, "_data"},  m_data,         64'd0);
        chk({nm, "_last"},  64'(m_last),    64'd0);
        chk({nm, "_busy"},  64'(busy),      64'd0);
        chk({nm, "_done"},  64'(done),      64'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_xfer("basic",  12'h010, 8, 0, 0, 0);
        run_xfer("wrap",   12'hFFE, 4, 0, 0, 0);
        run_xfer("stall",  12'($urandom), 16, 2, 0, 0);
        run_xfer("zero",   12'h123, 0, 0, 0, 0);
        run_xfer("one",    12'h7FF, 1, 0, 0, 0);
        run_xfer("restart", 12'h100, 8, 0, 4, 0);

        run_xfer("midrst", 12'h200, 8, 0, 0, 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run_xfer("post_rst", 12'h300, 2, 0, 0, 0);

        for (int r = 0; r < 3; r++) begin
            run_xfer("rand", 12'($urandom), $urandom_range(1, 40), 1, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pool5_rm_reader.md
Name: pool5_rm_reader

Overview:
- Downstream read controller for the pool5 result RAM, a simple dual-port memory with a 64-bit word and 2-cycle read latency.
- On a start pulse it reads a contiguous run of words through the RAM read port and presents them as a valid/ready stream to the next layer's input (fc6 loader).
- It hides the fixed RAM read latency with a credit-limited output FIFO, so backpressure never drops or duplicates a word.

Parameters:
- ADDR_W, 12, RAM read address width.
- DATA_W, 64, RAM word and stream data width.
- RD_LAT, 2, RAM read latency in cycles (address to doutb).
- FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LAT+2 and a power of two.

Ports:
- clk  in  1  single clock for all logic; also drives the RAM.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a transfer; ignored while busy=1.
- base_addr  in  ADDR_W  first RAM word address, sampled on an accepted start.
- word_cnt  in  ADDR_W+1  number of words to transfer (0..2^ADDR_W), sampled on an accepted start.
- ram_addrb  out  ADDR_W  RAM read address; the RAM read enable is tied high.
- ram_doutb  in  DATA_W  RAM read data, valid RD_LAT cycles after the address.
- m_valid  out  1  stream word valid.
- m_data  out  DATA_W  stream word.
- m_last  out  1  high on the final word of the transfer.
- m_ready  in  1  downstream accept.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse after the last word handshakes.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: ram_addrb=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0; FIFO empty, all counters 0, state IDLE.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE: on start, latch base_addr into addr_q and word_cnt into issue_rem and out_rem.
  - word_cnt=0 -> FIN.
  - otherwise -> ISSUE; busy=1 from the next cycle.
- ISSUE: issue one read per cycle when issue_rem>0 and inflight+fifo_count < FIFO_DEPTH (credit check).
  - An issue drives ram_addrb=addr_q, then increments addr_q modulo 2^ADDR_W (wraps 4095->0) and decrements issue_rem.
  - When issue_rem reaches 0 -> DRAIN.
- Read pipeline: an RD_LAT-deep valid shift register tags each issue; a tagged ram_doutb is written into the FIFO exactly RD_LAT cycles after its address.
  - The credit check guarantees the FIFO never overflows; no write is ever dropped.
- Output: m_valid = FIFO not empty; m_data = FIFO head (show-ahead, no extra latency).
  - Pop on m_valid & m_ready.
  - m_last = m_valid & (out_rem==1); out_rem decrements on each pop.
  - m_data/m_last stay stable while m_valid=1 and m_ready=0.
- DRAIN: wait until out_rem=0 after a pop -> FIN.
- FIN: done=1 for exactly one cycle, busy=0, -> IDLE.
  - For word_cnt=0: done pulses 2 cycles after start and no beat is emitted.
- Latency: first m_valid is RD_LAT+1 cycles after the accepted start.
  - With m_ready held high, throughput is 1 word/cycle with no bubbles.
- Simultaneous FIFO write and pop in one cycle: fifo_count is unchanged.
- start while busy=1 is ignored; transfer parameters are unaffected.
- Reset mid-transfer: asynchronous clear to reset values; in-flight RAM data is discarded; no done pulse.

Optional Feature:
- Macro: POOL5_RD_REPEAT_EN.
- With it defined: adds input num_pass (4 bits, sampled on start; 0 is treated as 1).
  - The same base_addr/word_cnt run is streamed num_pass times back-to-back with no idle cycles between passes.
  - m_last asserts only on the final word of the final pass; done pulses once at the end.
- Without it: the port is absent and behaviour is a single pass.

Test Plan:
- base_addr=0x010, word_cnt=8, m_ready=1 -> data from addresses 0x010..0x017 in order, first m_valid at start+3, 8 consecutive beats, m_last on beat 8, done 1 cycle after.
- base_addr=0xFFE, word_cnt=4 -> reads 0xFFE, 0xFFF, 0x000, 0x001 in order (address wrap).
- word_cnt=16, m_ready toggling 1/0 each cycle plus a 10-cycle stall -> all 16 words delivered exactly once, in order, data stable during stalls; ram_addrb issue pauses while credit is exhausted.
- word_cnt=0 -> no m_valid, done pulses at start+2, busy never high for more than 1 cycle.
- Second start pulsed mid-transfer of word_cnt=8 -> ignored; exactly 8 beats and a single done.
- rst_n asserted after 3 beats of word_cnt=8 -> outputs at reset values immediately; a new start with word_cnt=2 yields exactly 2 fresh beats.
